// File: rtl/binary_conv3x3_pkg.sv
// Shared constants and helpers for the binary convolution stage
// and the max-pooling stage that consumes its feature map.
package binary_conv3x3_pkg;

    localparam int KERNEL_SIZE  = 3;
    localparam int KERNEL_BITS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int POPCNT_W     = 4;

    localparam int MNIST_WIDTH  = 28;
    localparam int MNIST_HEIGHT = 28;

    localparam int CONV_WIDTH   = MNIST_WIDTH - KERNEL_SIZE + 1;
    localparam int CONV_HEIGHT  = MNIST_HEIGHT - KERNEL_SIZE + 1;

    function automatic logic [POPCNT_W-1:0] popcount9(
        input logic [KERNEL_BITS-1:0] v
    );
        logic [POPCNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KERNEL_BITS; i++) begin
            cnt = cnt + POPCNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/binary_conv3x3_line_buffer.sv
// Two row shift registers plus the sliding 3x3 window; the window
// presented here already includes the pixel accepted on this edge.
module conv_line_buffer
    import binary_conv3x3_pkg::*;
#(
    parameter int IMG_WIDTH = MNIST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pixel_in,
    input  logic                   valid_in,
    input  logic                   pos_valid,
    output logic [KERNEL_BITS-1:0] window,
    output logic                   window_valid
);

    logic [IMG_WIDTH-1:0] line1;
    logic [IMG_WIDTH-1:0] line2;
    logic [5:0]           hist;
    logic [2:0]           col_new;

    // Oldest bit of each line is the same column one/two rows above.
    assign col_new = {line2[IMG_WIDTH-1], line1[IMG_WIDTH-1], pixel_in};

    assign window = {hist[5:4], col_new[2],
                     hist[3:2], col_new[1],
                     hist[1:0], col_new[0]};

    assign window_valid = valid_in & pos_valid;

    always_ff @(posedge clk) begin
        if (valid_in) begin
            line1 <= {line1[IMG_WIDTH-2:0], pixel_in};
            line2 <= {line2[IMG_WIDTH-2:0], line1[IMG_WIDTH-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (valid_in) begin
            hist <= {window[7:6], window[4:3], window[1:0]};
        end
    end

endmodule

// File: rtl/binary_conv3x3.sv
// Streaming 3x3 XNOR-popcount convolution over a raster 1-bit image,
// thresholded to a (W-2)x(H-2) binary feature map.
module binary_conv3x3
    import binary_conv3x3_pkg::*;
#(
    parameter int                     IMG_WIDTH  = MNIST_WIDTH,
    parameter int                     IMG_HEIGHT = MNIST_HEIGHT,
    parameter logic [KERNEL_BITS-1:0] WEIGHTS    = 9'h1FF,
    parameter int                     THRESHOLD  = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pixel_in,
    input  logic valid_in,
    output logic conv_out,
    output logic valid_out_conv,
    output logic frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]    COL_MIN  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0]    ROW_MIN  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [POPCNT_W-1:0] THR      = POPCNT_W'(THRESHOLD);

    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic                   col_last;
    logic                   row_last;
    logic                   pos_valid;
    logic [KERNEL_BITS-1:0] window;
    logic                   window_valid;
    logic [KERNEL_BITS-1:0] match;
    logic [POPCNT_W-1:0]    popcnt;
    logic                   hit;

    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);
    assign pos_valid = (col >= COL_MIN) && (row >= ROW_MIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv_line_buffer #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_line_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .pos_valid    (pos_valid),
        .window       (window),
        .window_valid (window_valid)
    );

    assign match  = ~(window ^ WEIGHTS);
    assign popcnt = popcount9(match);
    assign hit    = (popcnt >= THR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_out       <= 1'b0;
            valid_out_conv <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            valid_out_conv <= window_valid;
            frame_done     <= window_valid & col_last & row_last;
            if (window_valid) begin
                conv_out <= hit;
            end
        end
    end

endmodule

// File: tb/tb_binary_conv3x3.sv
// Directed bench: five kernel/threshold variants share one pixel stream
// and are compared against a window-level reference model.
module tb_binary_conv3x3;
    import binary_conv3x3_pkg::*;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int CW   = W - 2;
    localparam int CH   = H - 2;
    localparam int NOUT = CW * CH;
    localparam int ND   = 5;
    localparam int NV   = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pixel_in = 1'b0;
    logic valid_in = 1'b0;
    logic [ND-1:0] co;
    logic [ND-1:0] vo;
    logic [ND-1:0] fd;

    always #5 clk = ~clk;

    binary_conv3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H),
                     .WEIGHTS(9'h1FF), .THRESHOLD(9)) u_a (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .conv_out(co[0]), .valid_out_conv(vo[0]), .frame_done(fd[0]));
    binary_conv3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H),
                     .WEIGHTS(9'h1FF), .THRESHOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .conv_out(co[1]), .valid_out_conv(vo[1]), .frame_done(fd[1]));
    binary_conv3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H),
                     .WEIGHTS(9'h000), .THRESHOLD(1)) u_c (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .conv_out(co[2]), .valid_out_conv(vo[2]), .frame_done(fd[2]));
    binary_conv3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H),
                     .WEIGHTS(9'b000010000), .THRESHOLD(9)) u_d (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .conv_out(co[3]), .valid_out_conv(vo[3]), .frame_done(fd[3]));
    binary_conv3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H),
                     .WEIGHTS(9'h1FF), .THRESHOLD(5)) u_e (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .conv_out(co[4]), .valid_out_conv(vo[4]), .frame_done(fd[4]));

    typedef struct {
        int pat;
        bit gaps;
        int o0, o1, o2, o3, o4;
    } vec_t;

    vec_t tv [0:NV-1];
    bit   img [0:7][0:H-1][0:W-1];
    bit   outs [0:ND-1][0:8191];
    int   nout [0:ND-1];
    int   fd_pos [0:15];
    int   fd_cnt;
    int   acc_cnt;
    int   first_at;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int pat, bit gaps,
                                int o0, int o1, int o2, int o3, int o4);
        vec_t v;
        v.pat = pat; v.gaps = gaps;
        v.o0 = o0; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.o4 = o4;
        return v;
    endfunction

    function automatic int exp_ones(vec_t v, int k);
        case (k)
            0: return v.o0;
            1: return v.o1;
            2: return v.o2;
            3: return v.o3;
            default: return v.o4;
        endcase
    endfunction

    function automatic logic [8:0] dut_w(int k);
        case (k)
            0, 1, 4: return 9'h1FF;
            2: return 9'h000;
            default: return 9'b000010000;
        endcase
    endfunction

    function automatic int dut_t(int k);
        case (k)
            0, 3: return 9;
            1, 2: return 1;
            default: return 5;
        endcase
    endfunction

    function automatic bit model(int k, int s, int i, int j);
        logic [8:0] win;
        logic [8:0] w;
        int pc;
        w = dut_w(k);
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                win[8 - (3 * dr + dc)] = img[s][i + dr][j + dc];
        pc = 0;
        for (int b = 0; b < 9; b++)
            if (win[b] == w[b]) pc++;
        return pc >= dut_t(k);
    endfunction

    task automatic fill_img(input int s, input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0: img[s][r][c] = 1'b0;
                    1: img[s][r][c] = 1'b1;
                    2: img[s][r][c] = (r == 5) && (c == 5);
                    3: img[s][r][c] = ((r + c) % 2) == 0;
                    4: img[s][r][c] = ((r + c) % 2) == 1;
                    default: img[s][r][c] = 1'($urandom_range(0, 1));
                endcase
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < ND; k++) nout[k] = 0;
        fd_cnt = 0;
        acc_cnt = 0;
        first_at = -1;
    endtask

    task automatic sample();
        for (int k = 0; k < ND; k++)
            if (vo[k] && nout[k] < 8192) begin
                outs[k][nout[k]] = co[k];
                nout[k]++;
            end
        if (fd[4] && fd_cnt < 16) begin
            fd_pos[fd_cnt] = nout[4] - 1;
            fd_cnt++;
        end
        if (vo[4] && first_at < 0) first_at = acc_cnt;
    endtask

    task automatic cycle(input bit v, input bit p);
        @(negedge clk);
        sample();
        valid_in = v;
        pixel_in = p;
        if (v && rst_n) acc_cnt++;
    endtask

    task automatic run_pixels(input int s, input bit gaps, input int n);
        for (int idx = 0; idx < n; idx++) begin
            if (gaps && $urandom_range(0, 1) == 1) cycle(1'b0, 1'b0);
            cycle(1'b1, img[s][idx / W][idx % W]);
        end
    endtask

    task automatic check_frame(input int s, input int base, input vec_t v);
        int mism;
        int ones;
        for (int k = 0; k < ND; k++) begin
            mism = 0;
            ones = 0;
            for (int i = 0; i < CH; i++)
                for (int j = 0; j < CW; j++) begin
                    if (outs[k][base + i * CW + j] != model(k, s, i, j)) mism++;
                    if (outs[k][base + i * CW + j]) ones++;
                end
            check($sformatf("content_f%0d_d%0d", s, k), mism, 0);
            if (exp_ones(v, k) >= 0)
                check($sformatf("ones_f%0d_d%0d", s, k), ones, exp_ones(v, k));
        end
    endtask

    initial begin
        tv[0] = mk(0, 1'b0, 0, 0, NOUT, 0, 0);
        tv[1] = mk(1, 1'b0, NOUT, NOUT, 0, 0, NOUT);
        tv[2] = mk(2, 1'b0, 0, 9, NOUT, 1, 0);
        tv[3] = mk(3, 1'b1, 0, NOUT, NOUT, 0, 338);
        tv[4] = mk(2, 1'b1, 0, 9, NOUT, 1, 0);
        tv[5] = mk(4, 1'b0, 0, NOUT, NOUT, 0, 338);
        tv[6] = mk(5, 1'b1, -1, -1, -1, -1, -1);
        clear_mon();

        rst_n = 1'b0;
        repeat (3) cycle(1'b0, 1'b0);
        @(negedge clk);
        check("reset_valid", int'(vo), 0);
        check("reset_conv", int'(co), 0);
        check("reset_done", int'(fd), 0);
        rst_n = 1'b1;
        clear_mon();

        for (int f = 0; f < NV; f++) begin
            fill_img(f, tv[f].pat);
            run_pixels(f, tv[f].gaps, W * H);
        end
        repeat (3) cycle(1'b0, 1'b0);

        check("first_valid_pixel", first_at, 2 * W + 3);
        for (int k = 0; k < ND; k++)
            check($sformatf("count_d%0d", k), nout[k], NV * NOUT);
        check("frame_done_count", fd_cnt, NV);
        for (int f = 0; f < NV && f < fd_cnt; f++)
            check($sformatf("frame_done_pos_f%0d", f), fd_pos[f],
                  f * NOUT + NOUT - 1);
        check("single_hot_idx108", int'(outs[3][2 * NOUT + 108]), 1);
        for (int f = 0; f < NV; f++) check_frame(f, f * NOUT, tv[f]);

        clear_mon();
        run_pixels(6, 1'b0, 300);
        @(negedge clk);
        sample();
        rst_n = 1'b0;
        valid_in = 1'b1;
        pixel_in = 1'b1;
        @(negedge clk);
        check("midreset_valid", int'(vo), 0);
        check("midreset_conv", int'(co), 0);
        check("midreset_done", int'(fd), 0);
        rst_n = 1'b1;
        valid_in = 1'b0;
        clear_mon();
        fill_img(7, 3);
        run_pixels(7, 1'b0, W * H);
        repeat (3) cycle(1'b0, 1'b0);
        check("post_reset_first", first_at, 2 * W + 3);
        for (int k = 0; k < ND; k++)
            check($sformatf("post_reset_count_d%0d", k), nout[k], NOUT);
        check("post_reset_done_cnt", fd_cnt, 1);
        check("post_reset_done_pos", fd_pos[0], NOUT - 1);
        check_frame(7, 0, mk(3, 1'b0, 0, NOUT, NOUT, 0, 338));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_conv3x3.md
# binary_conv3x3

Streaming 3x3 binary convolution stage that sits directly upstream of the 2x2 max-pooling stage. It accepts a raster-ordered 1-bit image (MNIST 28x28 after binarisation) and computes an XNOR-popcount against a fixed 9-bit kernel at every fully-covered window position. It thresholds the result and emits the 26x26 binary feature map, one bit per valid flag, in raster order. That output feeds the max-pooling stage, whose WIDTH/HEIGHT equal IMG_WIDTH-2 / IMG_HEIGHT-2.

## Interface
- IMG_WIDTH, 28, input image columns (>=3)
- IMG_HEIGHT, 28, input image rows (>=3)
- WEIGHTS, 9'h1FF, kernel bits; bit 8 = top-left, bit 6 = top-right, bit 2 = bottom-left, bit 0 = bottom-right (row-major)
- THRESHOLD, 5, output is 1 when popcount >= THRESHOLD (range 0..9)
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- pixel_in  input  1  image pixel, raster order (row-major, top-left first)
- valid_in  input  1  pixel_in is accepted on this edge
- conv_out  output  1  thresholded convolution bit
- valid_out_conv  output  1  conv_out is valid this cycle (1-cycle pulse per output)
- frame_done  output  1  pulses with the last output of a frame (output 25,25 for defaults)

## Operation
- No back-pressure: every cycle with valid_in=1 accepts one pixel. Idle cycles (valid_in=0) freeze all state.
- Counters:
  - col: 0..IMG_WIDTH-1, advances per accepted pixel.
  - row: 0..IMG_HEIGHT-1, advances when col wraps.
  - Both wrap to 0 after pixel (IMG_HEIGHT-1, IMG_WIDTH-1); the next accepted pixel starts a new frame with no gap cycle.
- Line storage: two row buffers of IMG_WIDTH bits hold rows r-1 and r-2. A 3x3 window register shifts in one column per accepted pixel: {row r-2, row r-1, incoming pixel}.
- Window valid when the accepted pixel has row>=2 and col>=2. Window bottom-right = that pixel; output index = (row-2, col-2).
- Arithmetic:
  - match = ~(window ^ WEIGHTS), 9 bits.
  - popcount is 4 bits, 0..9.
  - conv_out = (popcount >= THRESHOLD).
  - Unsigned compare; THRESHOLD=0 yields all ones.
- No state machine beyond the counters; row-buffer contents for rows 0-1 of a new frame are stale but gated by row>=2.
- Reset (any time, including mid-frame):
  - counters, window, valid_out_conv, conv_out and frame_done go to 0.
  - Row-buffer contents need not be cleared.
  - The next accepted pixel is treated as (0,0).

## Timing
- Latency: conv_out/valid_out_conv register one cycle after the edge that accepts the window's bottom-right pixel.
- First output of a frame follows accepted pixel index 2*IMG_WIDTH+2 (58 for defaults).
- Outputs per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2) = 676. No valid during col<2 or row<2 pixels.
- valid_out_conv is high for exactly one cycle per window. Consecutive accepted pixels give back-to-back valids.
- frame_done is coincident with valid_out_conv for output (IMG_HEIGHT-3, IMG_WIDTH-3).
- conv_out holds its last value when valid_out_conv=0. Consumers must qualify conv_out with valid_out_conv.
- Reset values: conv_out=0, valid_out_conv=0, frame_done=0.

## Structure
- Shared package constants:
  - KERNEL_SIZE=3
  - POPCNT_W=4
  - default MNIST dimensions (28) and derived conv dimensions (26), also used by the max-pooling instantiation.
- One sub-module: conv_line_buffer. It holds the two IMG_WIDTH-deep row shift registers and the 3x3 window, and exposes the 9-bit window and a window_valid strobe. The top level adds the counters, XNOR-popcount, threshold register and frame_done.

## Test plan
- All-ones 28x28 image, WEIGHTS=9'h1FF, THRESHOLD=9 -> exactly 676 valid pulses, all conv_out=1; frame_done on the 676th.
- All-zeros image, WEIGHTS=9'h1FF, THRESHOLD=1 -> 676 zeros. Same image with WEIGHTS=9'h000 -> 676 ones.
- Single 1 at pixel (5,5), rest 0, WEIGHTS=9'b000010000, THRESHOLD=9 -> only output index 108 (4,4) is 1; all others 0 (popcount 8).
- Continuous valid_in from reset release -> first valid_out_conv exactly 1 cycle after the 59th accepted pixel. Random valid_in gaps (~50%) -> identical output sequence.
- Two frames back-to-back, second frame inverted -> second frame's 676 outputs match the model with no corruption from first-frame row buffers.
- rst_n low for one cycle after 300 pixels of a frame, then a full frame -> no output during the partial frame after reset. The full frame produces exactly 676 correct outputs.
